// File: rtl/ex_alu_fwd_core.sv
// ex_alu_fwd_core: MIPS EX-stage compute core.
// Combines the forwarding unit, the ALU-control decoder, a 32-bit ALU and
// BEQ/BNE resolution. ALU result, store data, destination register and the
// five pass-through control bits are captured into the EX/MEM register.
// The branch outcome and misprediction flag are combinational so that
// fetch redirection is not delayed by a cycle.
module ex_alu_fwd_core #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] i_read_data_1,
   input  logic [DATA_W-1:0] i_read_data_2,
   input  logic [DATA_W-1:0] i_imm,
   input  logic [5:0]        i_function,
   input  logic [5:0]        i_opcode,
   input  logic [4:0]        i_rs,
   input  logic [4:0]        i_rt,
   input  logic [4:0]        i_rd,
   input  logic              i_alu_src,
   input  logic [1:0]        i_alu_op,
   input  logic              i_reg_dst,
   input  logic              i_reg_write,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic              i_mem_to_reg,
   input  logic              i_branch,
   input  logic              i_branch_prediction,
   input  logic [4:0]        i_mem_write_register,
   input  logic              i_mem_reg_write,
   input  logic [DATA_W-1:0] i_mem_alu_result,
   input  logic [4:0]        i_wb_write_register,
   input  logic              i_wb_reg_write,
   input  logic [DATA_W-1:0] i_wb_write_data,
   output logic [DATA_W-1:0] o_alu_result,
   output logic [DATA_W-1:0] o_store_data,
   output logic [4:0]        o_write_register,
   output logic              o_reg_write,
   output logic              o_mem_read,
   output logic              o_mem_write,
   output logic              o_mem_to_reg,
   output logic              o_branch,
   output logic              o_branch_taken,
   output logic              o_mispredicted
);

   // 4-bit ALU operation codes as seen on the internal ALU-control bus.
   typedef enum logic [3:0] {
      ALU_AND     = 4'b0000,
      ALU_OR      = 4'b0001,
      ALU_ADD     = 4'b0010,
      ALU_XOR     = 4'b0011,
      ALU_SUB     = 4'b0110,
      ALU_SLT     = 4'b0111,
      ALU_SLTU    = 4'b1000,
      ALU_NOR     = 4'b1100,
      ALU_INVALID = 4'b1111
   } alu_ctrl_t;

   localparam logic [5:0] OPC_BEQ = 6'b000100;
   localparam logic [5:0] OPC_BNE = 6'b000101;

   logic [DATA_W-1:0] fwd_a;
   logic [DATA_W-1:0] fwd_b;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_result;
   logic [4:0]        dest_reg;
   logic              is_equal;
   alu_ctrl_t         alu_ctrl;

   // Select the freshest value of a source register. The MEM stage holds a
   // younger result than WB, so it is checked first; $0 is hard-wired to
   // zero and must never pick up a pending write.
   function automatic logic [DATA_W-1:0] forward(
      input logic [4:0]        src,
      input logic [DATA_W-1:0] reg_val,
      input logic [4:0]        mem_reg,
      input logic              mem_we,
      input logic [DATA_W-1:0] mem_val,
      input logic [4:0]        wb_reg,
      input logic              wb_we,
      input logic [DATA_W-1:0] wb_val
   );
      if (mem_we && (mem_reg != 5'd0) && (mem_reg == src)) begin
         return mem_val;
      end else if (wb_we && (wb_reg != 5'd0) && (wb_reg == src)) begin
         return wb_val;
      end
      return reg_val;
   endfunction

   // Forwarding muxes for both source operands.
   always_comb begin
      fwd_a = forward(i_rs, i_read_data_1,
                      i_mem_write_register, i_mem_reg_write, i_mem_alu_result,
                      i_wb_write_register, i_wb_reg_write, i_wb_write_data);
      fwd_b = forward(i_rt, i_read_data_2,
                      i_mem_write_register, i_mem_reg_write, i_mem_alu_result,
                      i_wb_write_register, i_wb_reg_write, i_wb_write_data);
   end

   // Operand B is the immediate for I-type arithmetic and memory ops.
   assign alu_b = i_alu_src ? i_imm : fwd_b;

   // ALU-control decoder: alu_op class first, funct field for R-type.
   always_comb begin
      // NOTE: every combinational output gets a default before the case so
      // that an unlisted encoding cannot leave it unassigned and infer a latch.
      alu_ctrl = ALU_INVALID;
      case (i_alu_op)
         2'b00: alu_ctrl = ALU_ADD;
         2'b01: alu_ctrl = ALU_SUB;
         2'b11: alu_ctrl = ALU_ADD;
         2'b10: begin
            case (i_function)
               6'b100000, 6'b100001: alu_ctrl = ALU_ADD;
               6'b100010, 6'b100011: alu_ctrl = ALU_SUB;
               6'b100100:            alu_ctrl = ALU_AND;
               6'b100101:            alu_ctrl = ALU_OR;
               6'b100110:            alu_ctrl = ALU_XOR;
               6'b100111:            alu_ctrl = ALU_NOR;
               6'b101010:            alu_ctrl = ALU_SLT;
               6'b101011:            alu_ctrl = ALU_SLTU;
               default:              alu_ctrl = ALU_INVALID;
            endcase
         end
         default: alu_ctrl = ALU_INVALID;
      endcase
   end

   // ALU datapath; arithmetic wraps modulo 2^DATA_W with no overflow trap.
   always_comb begin
      alu_result = '0;
      case (alu_ctrl)
         ALU_AND:  alu_result = fwd_a & alu_b;
         ALU_OR:   alu_result = fwd_a | alu_b;
         ALU_ADD:  alu_result = fwd_a + alu_b;
         ALU_XOR:  alu_result = fwd_a ^ alu_b;
         ALU_SUB:  alu_result = fwd_a - alu_b;
         ALU_NOR:  alu_result = ~(fwd_a | alu_b);
         ALU_SLT:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
         ALU_SLTU: alu_result = {{(DATA_W-1){1'b0}}, (fwd_a < alu_b)};
         default:  alu_result = '0;
      endcase
   end

   // Branch compare uses the forwarded register pair, never the immediate.
   assign is_equal = (fwd_a == fwd_b);

   // Branch resolution and misprediction detection, zero latency.
   always_comb begin
      o_branch_taken = i_branch &
                       (((i_opcode == OPC_BEQ) &  is_equal) |
                        ((i_opcode == OPC_BNE) & ~is_equal));
      o_mispredicted = i_branch & (o_branch_taken != i_branch_prediction);
   end

   assign dest_reg = i_reg_dst ? i_rd : i_rt;

   // EX/MEM pipeline register; reset asynchronously discards the in-flight op.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_alu_result     <= '0;
         o_store_data     <= '0;
         o_write_register <= '0;
         o_reg_write      <= 1'b0;
         o_mem_read       <= 1'b0;
         o_mem_write      <= 1'b0;
         o_mem_to_reg     <= 1'b0;
         o_branch         <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every flop samples the
         // pre-edge values, independent of statement order.
         o_alu_result     <= alu_result;
         o_store_data     <= fwd_b;
         o_write_register <= dest_reg;
         o_reg_write      <= i_reg_write;
         o_mem_read       <= i_mem_read;
         o_mem_write      <= i_mem_write;
         o_mem_to_reg     <= i_mem_to_reg;
         o_branch         <= i_branch;
      end
   end

endmodule

// File: tb/tb_ex_alu_fwd_core.sv
// Directed, table-driven bench for ex_alu_fwd_core. Inputs change on the
// falling edge; combinational branch outputs are sampled 1 ns later and the
// registered outputs 1 ns after the following rising edge.
module tb_ex_alu_fwd_core;

   typedef struct {
      string       name;
      logic [31:0] rd1, rd2, imm;
      logic [5:0]  funct, opcode;
      logic [4:0]  rs, rt, rd;
      logic        alu_src;
      logic [1:0]  alu_op;
      logic        reg_dst;
      logic [4:0]  ctrl;        // reg_write, mem_read, mem_write, mem_to_reg, branch
      logic        pred;
      logic [4:0]  mem_reg;
      logic        mem_we;
      logic [31:0] mem_val;
      logic [4:0]  wb_reg;
      logic        wb_we;
      logic [31:0] wb_val;
      logic [31:0] exp_result, exp_store;
      logic [4:0]  exp_wreg;
      logic        exp_taken, exp_mispred;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] read_data_1, read_data_2, imm;
   logic [5:0]  funct, opcode;
   logic [4:0]  rs, rt, rd;
   logic        alu_src;
   logic [1:0]  alu_op;
   logic        reg_dst;
   logic        reg_write, mem_read, mem_write, mem_to_reg, branch;
   logic        branch_prediction;
   logic [4:0]  mem_write_register;
   logic        mem_reg_write;
   logic [31:0] mem_alu_result;
   logic [4:0]  wb_write_register;
   logic        wb_reg_write;
   logic [31:0] wb_write_data;
   logic [31:0] alu_result, store_data;
   logic [4:0]  write_register;
   logic        o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_branch;
   logic        branch_taken, mispredicted;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   ex_alu_fwd_core #(.DATA_W(32)) dut (
      .clk                  (clk),
      .reset                (reset),
      .i_read_data_1        (read_data_1),
      .i_read_data_2        (read_data_2),
      .i_imm                (imm),
      .i_function           (funct),
      .i_opcode             (opcode),
      .i_rs                 (rs),
      .i_rt                 (rt),
      .i_rd                 (rd),
      .i_alu_src            (alu_src),
      .i_alu_op             (alu_op),
      .i_reg_dst            (reg_dst),
      .i_reg_write          (reg_write),
      .i_mem_read           (mem_read),
      .i_mem_write          (mem_write),
      .i_mem_to_reg         (mem_to_reg),
      .i_branch             (branch),
      .i_branch_prediction  (branch_prediction),
      .i_mem_write_register (mem_write_register),
      .i_mem_reg_write      (mem_reg_write),
      .i_mem_alu_result     (mem_alu_result),
      .i_wb_write_register  (wb_write_register),
      .i_wb_reg_write       (wb_reg_write),
      .i_wb_write_data      (wb_write_data),
      .o_alu_result         (alu_result),
      .o_store_data         (store_data),
      .o_write_register     (write_register),
      .o_reg_write          (o_reg_write),
      .o_mem_read           (o_mem_read),
      .o_mem_write          (o_mem_write),
      .o_mem_to_reg         (o_mem_to_reg),
      .o_branch             (o_branch),
      .o_branch_taken       (branch_taken),
      .o_mispredicted       (mispredicted)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t blank(input string name);
      vec_t v;
      v.name = name;
      v.rd1 = 0; v.rd2 = 0; v.imm = 0;
      v.funct = 6'b100000; v.opcode = 6'b000000;
      v.rs = 5'd1; v.rt = 5'd2; v.rd = 5'd3;
      v.alu_src = 0; v.alu_op = 2'b10; v.reg_dst = 1;
      v.ctrl = 5'b10000; v.pred = 0;
      v.mem_reg = 0; v.mem_we = 0; v.mem_val = 0;
      v.wb_reg = 0; v.wb_we = 0; v.wb_val = 0;
      v.exp_result = 0; v.exp_store = 0; v.exp_wreg = 5'd3;
      v.exp_taken = 0; v.exp_mispred = 0;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      read_data_1 = v.rd1; read_data_2 = v.rd2; imm = v.imm;
      funct = v.funct; opcode = v.opcode;
      rs = v.rs; rt = v.rt; rd = v.rd;
      alu_src = v.alu_src; alu_op = v.alu_op; reg_dst = v.reg_dst;
      {reg_write, mem_read, mem_write, mem_to_reg, branch} = v.ctrl;
      branch_prediction = v.pred;
      mem_write_register = v.mem_reg; mem_reg_write = v.mem_we; mem_alu_result = v.mem_val;
      wb_write_register = v.wb_reg; wb_reg_write = v.wb_we; wb_write_data = v.wb_val;
   endtask

   task automatic check_regs_zero(input string tag);
      check({tag, " result"}, alu_result, 32'd0);
      check({tag, " store"}, store_data, 32'd0);
      check({tag, " wreg"}, {27'd0, write_register}, 32'd0);
      check({tag, " ctrl"}, {27'd0, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_branch}, 32'd0);
   endtask

   initial begin
      vec_t v;

      // ---------------- vector table ----------------
      v = blank("add_nohaz"); v.rd1 = 5; v.rd2 = 7; v.exp_result = 12; v.exp_store = 7; vecs.push_back(v);

      v = blank("mem_over_wb"); v.rs = 4; v.rd1 = 1; v.rt = 5; v.rd2 = 30; v.funct = 6'b100010;
      v.mem_reg = 4; v.mem_we = 1; v.mem_val = 100; v.wb_reg = 4; v.wb_we = 1; v.wb_val = 200;
      v.rd = 6; v.exp_wreg = 6; v.exp_result = 70; vecs.push_back(v);
      v.name = "wb_only"; v.mem_we = 0; v.exp_result = 170; vecs.push_back(v);
      v.exp_store = 30; vecs[1].exp_store = 30; vecs[2].exp_store = 30;

      v = blank("zero_guard"); v.rs = 0; v.rd1 = 0; v.mem_reg = 0; v.mem_we = 1; v.mem_val = 99;
      v.alu_op = 2'b00; v.alu_src = 1; v.imm = 8; v.rt = 9; v.rd2 = 32'h55; v.reg_dst = 0;
      v.ctrl = 5'b11010; v.exp_result = 8; v.exp_store = 32'h55; v.exp_wreg = 9; vecs.push_back(v);

      v = blank("slt_signed"); v.rd1 = 32'hFFFF_FFFF; v.rd2 = 1; v.funct = 6'b101010;
      v.exp_result = 1; v.exp_store = 1; vecs.push_back(v);
      v.name = "sltu_big_a"; v.funct = 6'b101011; v.exp_result = 0; vecs.push_back(v);
      v = blank("sltu_small_a"); v.rd1 = 1; v.rd2 = 32'hFFFF_FFFF; v.funct = 6'b101011;
      v.exp_result = 1; v.exp_store = 32'hFFFF_FFFF; vecs.push_back(v);
      v.name = "slt_pos_vs_neg"; v.funct = 6'b101010; v.exp_result = 0; vecs.push_back(v);
      v = blank("invalid_funct"); v.rd1 = 32'hFFFF_FFFF; v.rd2 = 1; v.funct = 6'b111111;
      v.exp_result = 0; v.exp_store = 1; vecs.push_back(v);

      v = blank("and"); v.rd1 = 32'hF0F0_F0F0; v.rd2 = 32'h0FF0_0FF0; v.funct = 6'b100100;
      v.exp_store = 32'h0FF0_0FF0; v.exp_result = 32'h00F0_00F0; vecs.push_back(v);
      v.name = "or";  v.funct = 6'b100101; v.exp_result = 32'hFFF0_FFF0; vecs.push_back(v);
      v.name = "xor"; v.funct = 6'b100110; v.exp_result = 32'hFF00_FF00; vecs.push_back(v);
      v.name = "nor"; v.funct = 6'b100111; v.exp_result = 32'h000F_000F; vecs.push_back(v);

      v = blank("beq_ne_wrap"); v.rd1 = 0; v.rd2 = 1; v.alu_op = 2'b01; v.opcode = 6'b000100;
      v.ctrl = 5'b00001; v.reg_dst = 0; v.exp_wreg = 2; v.exp_result = 32'hFFFF_FFFF; v.exp_store = 1;
      vecs.push_back(v);
      v = blank("beq_eq_p0"); v.rd1 = 32'h1234; v.rd2 = 32'h1234; v.alu_op = 2'b01; v.opcode = 6'b000100;
      v.ctrl = 5'b00001; v.reg_dst = 0; v.exp_wreg = 2; v.exp_store = 32'h1234;
      v.exp_result = 0; v.exp_taken = 1; v.exp_mispred = 1; vecs.push_back(v);
      v.name = "bne_eq_p0"; v.opcode = 6'b000101; v.exp_taken = 0; v.exp_mispred = 0; vecs.push_back(v);

      v = blank("bne_fwd_wb_p1"); v.rs = 7; v.rd1 = 10; v.rt = 8; v.rd2 = 10; v.wb_reg = 7; v.wb_we = 1;
      v.wb_val = 11; v.alu_op = 2'b01; v.opcode = 6'b000101; v.ctrl = 5'b00001; v.pred = 1;
      v.reg_dst = 0; v.exp_wreg = 8; v.exp_result = 1; v.exp_store = 10; v.exp_taken = 1; vecs.push_back(v);

      v = blank("beq_ignores_imm"); v.rd1 = 3; v.rd2 = 4; v.imm = 3; v.alu_src = 1; v.alu_op = 2'b00;
      v.opcode = 6'b000100; v.ctrl = 5'b00001; v.pred = 1; v.exp_result = 6; v.exp_store = 4;
      v.exp_mispred = 1; vecs.push_back(v);

      v = blank("branch_other_op"); v.rd1 = 5; v.rd2 = 5; v.alu_op = 2'b00; v.opcode = 6'b000010;
      v.ctrl = 5'b00001; v.pred = 1; v.exp_result = 10; v.exp_store = 5; v.exp_mispred = 1; vecs.push_back(v);

      v = blank("fwd_b_mem_wins"); v.rs = 3; v.rd1 = 2; v.rt = 12; v.rd2 = 1; v.funct = 6'b100001;
      v.mem_reg = 12; v.mem_we = 1; v.mem_val = 32'h40; v.wb_reg = 12; v.wb_we = 1; v.wb_val = 32'h77;
      v.rd = 13; v.exp_wreg = 13; v.exp_result = 32'h42; v.exp_store = 32'h40; vecs.push_back(v);

      v = blank("aluop11_add_wrap"); v.rd1 = 32'hFFFF_FFFF; v.imm = 2; v.alu_src = 1; v.alu_op = 2'b11;
      v.rd2 = 32'h9; v.exp_result = 1; v.exp_store = 9; vecs.push_back(v);

      v = blank("subu"); v.rd1 = 5; v.rd2 = 7; v.funct = 6'b100011;
      v.exp_result = 32'hFFFF_FFFE; v.exp_store = 7; vecs.push_back(v);

      v = blank("nobranch_beq_op"); v.rd1 = 9; v.rd2 = 9; v.opcode = 6'b000100; v.pred = 1;
      v.rd = 31; v.exp_wreg = 31; v.exp_result = 18; v.exp_store = 9; vecs.push_back(v);

      // ---------------- reset before any clock edge ----------------
      reset = 1'b0;
      apply(blank("idle"));
      #1;
      check_regs_zero("reset_async");
      apply(vecs[0]);
      @(posedge clk); #1;
      check_regs_zero("reset_hold");
      @(negedge clk);
      reset = 1'b1;

      // ---------------- one-cycle latency ----------------
      #1;
      check("latency_before_edge", alu_result, 32'd0);
      @(posedge clk); #1;
      check("latency_after_edge", alu_result, 32'd12);

      // ---------------- table ----------------
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         apply(vecs[i]);
         #1;
         check({vecs[i].name, " taken"}, {31'd0, branch_taken}, {31'd0, vecs[i].exp_taken});
         check({vecs[i].name, " mispred"}, {31'd0, mispredicted}, {31'd0, vecs[i].exp_mispred});
         @(posedge clk); #1;
         check({vecs[i].name, " result"}, alu_result, vecs[i].exp_result);
         check({vecs[i].name, " store"}, store_data, vecs[i].exp_store);
         check({vecs[i].name, " wreg"}, {27'd0, write_register}, {27'd0, vecs[i].exp_wreg});
         check({vecs[i].name, " ctrl"},
               {27'd0, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_branch},
               {27'd0, vecs[i].ctrl});
      end

      // ---------------- mid-cycle reset discards the in-flight result ----------------
      // The last table vector (result 18, wreg 31) is still applied and captured.
      #2;
      reset = 1'b0;
      #1;
      check_regs_zero("reset_mid");
      @(posedge clk); #1;
      check_regs_zero("reset_mid_hold");
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("reset_release_no_edge", alu_result, 32'd0);
      @(posedge clk); #1;
      check("reset_release_capture", alu_result, 32'd18);
      check("reset_release_wreg", {27'd0, write_register}, 32'd31);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_alu_fwd_core.md
Name: ex_alu_fwd_core

Overview:
- MIPS EX-stage compute core: forwarding unit, ALU-control decoder and 32-bit ALU in one block.
- Resolves RAW hazards from the MEM and WB stages, decodes the ALU operation, evaluates BEQ/BNE, and registers the results into the EX/MEM pipeline register.
- Sits between the ID/EX register and the MEM stage.

Parameters:
- DATA_W, 32, datapath width (only 32 is supported).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- i_read_data_1  in  32  rs value from ID/EX.
- i_read_data_2  in  32  rt value from ID/EX.
- i_imm  in  32  sign-extended immediate.
- i_function  in  6  funct field.
- i_opcode  in  6  opcode.
- i_rs, i_rt, i_rd  in  5 each  register specifiers.
- i_alu_src  in  1  1 = immediate as operand B.
- i_alu_op  in  2  ALU operation class.
- i_reg_dst  in  1  1 = rd is destination, 0 = rt.
- i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg, i_branch  in  1 each  control bits.
- i_branch_prediction  in  1  predicted taken.
- i_mem_write_register  in  5  MEM-stage destination register.
- i_mem_reg_write  in  1  MEM-stage write enable.
- i_mem_alu_result  in  32  MEM-stage forwarded value.
- i_wb_write_register  in  5  WB-stage destination register.
- i_wb_reg_write  in  1  WB-stage write enable.
- i_wb_write_data  in  32  WB-stage forwarded value.
- o_alu_result  out  32  registered ALU result.
- o_store_data  out  32  registered forwarded rt value.
- o_write_register  out  5  registered destination register.
- o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_branch  out  1 each  registered control bits.
- o_branch_taken  out  1  combinational.
- o_mispredicted  out  1  combinational.

Behaviour:
- Forwarding (combinational), operand A from rs:
  - MEM if i_mem_reg_write and i_mem_write_register != 0 and == i_rs.
  - Else WB if i_wb_reg_write and i_wb_write_register != 0 and == i_rs.
  - Else i_read_data_1.
  - MEM always wins when both stages match.
- Forwarding, forwarded B: same rules applied with i_rt.
- Register $0 is never forwarded.
- ALU operand B = i_alu_src ? i_imm : forwarded B.
- ALU control encoding:
  - i_alu_op 00 → ADD; 01 → SUB; 11 → ADD.
  - i_alu_op 10 → decode i_function:
    - 100000, 100001 → ADD.
    - 100010, 100011 → SUB.
    - 100100 → AND; 100101 → OR; 100110 → XOR; 100111 → NOR.
    - 101010 → SLT (signed); 101011 → SLTU.
    - Any other funct → INVALID.
- 4-bit ALU codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, SLTU 1000, NOR 1100, INVALID 1111.
- ALU arithmetic:
  - Modulo-2^32, no overflow trap.
  - SLT/SLTU produce 32'd1 or 32'd0.
  - INVALID produces 32'd0.
- Branch resolution:
  - is_equal = (forwarded A == forwarded B). This uses the register values, not the immediate.
  - o_branch_taken = i_branch & ((opcode 000100 & is_equal) | (opcode 000101 & !is_equal)).
  - i_branch with any other opcode → not taken.
  - o_mispredicted = i_branch & (o_branch_taken != i_branch_prediction).
  - Both branch outputs are purely combinational, with zero latency.
- Destination register = i_reg_dst ? i_rd : i_rt.
- EX/MEM register:
  - On each rising clk edge, captures the ALU result, forwarded B (as o_store_data), destination register and the five control bits. Latency is 1 cycle.
  - No enable and no flush.
- Reset:
  - reset low asynchronously clears all registered outputs to 0, with no clock needed.
  - Registered outputs hold 0 while reset is low.
  - Capture resumes at the first rising edge after release.
  - Asserting reset mid-operation discards the in-flight result.
- No simulation-only display statements in the RTL.

Test Plan:
- ADD with no hazard: rs = 5, rt = 7, alu_op 10, funct 100000, alu_src 0, reg_dst 1, rd = 3 → next cycle o_alu_result = 12, o_write_register = 3.
- MEM/WB priority: i_rs = 4 matches both stages, MEM = 100, WB = 200, i_read_data_1 = 1, SUB with rt = 30 → result 70. Repeat with i_mem_reg_write = 0 → result 170.
- $0 guard: i_rs = 0 with i_mem_write_register = 0, i_mem_reg_write = 1, MEM = 99, i_read_data_1 = 0 → no forwarding, ADD with imm 8 → result 8.
- SLT vs SLTU: A = 0xFFFFFFFF, B = 1 → SLT result 1, SLTU result 0. Unknown funct 111111 → result 0.
- Branch: BEQ with equal forwarded operands and prediction 0 → taken 1, mispredicted 1. BNE with equal operands and prediction 0 → taken 0, mispredicted 0.
- Reset: drive a nonzero result, then assert reset mid-cycle → all registered outputs go to 0 immediately and stay 0 until release.
